// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port BRAM.
// It supports lockable bursts and rejects out-of-range addresses.
// It also routes read-valid and error strobes back to the issuing requester.
module ram_arbiter #(
  parameter  int unsigned MEM_WIDTH = 32,
  parameter  int unsigned MEM_SIZE  = 24,
  localparam int unsigned ADDR_W    = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [MEM_WIDTH-1:0] wdata0,
  input  logic [MEM_WIDTH-1:0] wdata1,
  input  logic                 lock0,
  input  logic                 lock1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 err0,
  output logic                 err1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [MEM_WIDTH-1:0] rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [MEM_WIDTH-1:0] ram_di,
  input  logic [MEM_WIDTH-1:0] ram_dout
);

  // One extra bit so a power-of-two MEM_SIZE still compares correctly
  localparam logic [ADDR_W:0] SIZE_EXT = (ADDR_W+1)'(MEM_SIZE);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  logic       rr_prio_q, rr_prio_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic       err0_q, err0_d;
  logic       err1_q, err1_d;
  logic [1:0] rst_sync_q;
  logic       rst_int_n;
  logic       in_range0, in_range1;

  assign in_range0 = {1'b0, addr0} < SIZE_EXT;
  assign in_range1 = {1'b0, addr1} < SIZE_EXT;
  assign rst_int_n = rst_sync_q[1];

  // Reset release synchroniser: assertion is immediate, release takes two edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Ownership, round-robin pointer and per-requester response strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= FREE;
      rr_prio_q <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rr_prio_q <= rr_prio_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  // Grant selection, ownership update and RAM port drive
  always_comb begin
    owner_d   = owner_q;
    rr_prio_d = rr_prio_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_di    = '0;

    unique case (owner_q)
      FREE: begin
        if (req0 && (!req1 || !rr_prio_q)) begin
          gnt0 = 1'b1;
        end else if (req1) begin
          gnt1 = 1'b1;
        end
      end
      OWN0: begin
        if (req0) gnt0 = 1'b1;
        else      owner_d = FREE;
      end
      OWN1: begin
        if (req1) gnt1 = 1'b1;
        else      owner_d = FREE;
      end
      default: owner_d = FREE;
    endcase

    // No grants until reset has been released internally
    if (!rst_int_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      rr_prio_d = 1'b1;
      owner_d   = lock0 ? OWN0 : FREE;
      if (in_range0) begin
        ram_en   = 1'b1;
        ram_we   = we0;
        ram_addr = addr0;
        ram_di   = wdata0;
      end
    end

    if (gnt1) begin
      rr_prio_d = 1'b0;
      owner_d   = lock1 ? OWN1 : FREE;
      if (in_range1) begin
        ram_en   = 1'b1;
        ram_we   = we1;
        ram_addr = addr1;
        ram_di   = wdata1;
      end
    end

    rvalid0_d = gnt0 & in_range0 & ~we0;
    rvalid1_d = gnt1 & in_range1 & ~we1;
    err0_d    = gnt0 & ~in_range0;
    err1_d    = gnt1 & ~in_range1;
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata   = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomised traffic.
// A transaction-level reference model and a behavioural BRAM are used for checking.
module tb_ram_arbiter;

  localparam int unsigned MW = 32;
  localparam int unsigned MS = 24;
  localparam int unsigned AW = $clog2(MS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [MW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [MW-1:0] rdata, ram_di, ram_dout;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  ram_arbiter #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_dout(ram_dout)
  );

  function automatic logic [MW-1:0] preload(input int i);
    return MW'(32'hC0DE_0000 + i);
  endfunction

  // Behavioural single-port BRAM, registered write-first read; reloaded on reset
  logic [MW-1:0] ram [MS];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MS); i++) ram[i] <= preload(i);
      ram_dout <= '0;
    end else if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr] <= ram_di;
        ram_dout      <= ram_di;
      end else begin
        ram_dout <= ram[ram_addr];
      end
    end
  end

  // Reference model state: owner -1 = free, else requester index
  int            m_owner;
  int            m_prio;
  bit            m_rv0, m_rv1, m_err0, m_err1;
  logic [MW-1:0] m_rdata;
  logic [MW-1:0] m_mem [MS];
  int            m_g;
  int            w0, w1;
  bit            chk_wait;
  int            checks, errors;
  bit            p0, p1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_rv0 = 0; m_rv1 = 0; m_err0 = 0; m_err1 = 0;
    m_rdata = '0;
    for (int i = 0; i < int'(MS); i++) m_mem[i] = preload(i);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  // Called just after a falling edge with inputs applied; checks one cycle and advances the model
  task automatic cycle();
    bit r[2], w[2], l[2];
    int a[2];
    logic [MW-1:0] d[2];
    int g, nxt;
    bit ok;
    #1;
    r[0] = req0; r[1] = req1; w[0] = we0; w[1] = we1; l[0] = lock0; l[1] = lock1;
    a[0] = int'(addr0); a[1] = int'(addr1); d[0] = wdata0; d[1] = wdata1;

    check("rvalid0", 64'(rvalid0), 64'(m_rv0));
    check("rvalid1", 64'(rvalid1), 64'(m_rv1));
    check("err0", 64'(err0), 64'(m_err0));
    check("err1", 64'(err1), 64'(m_err1));
    if (m_rv0 || m_rv1) check("rdata", 64'(rdata), 64'(m_rdata));

    g = -1;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (r[0] && r[1]) g = m_prio;
      else if (r[0])    g = 0;
      else if (r[1])    g = 1;
    end else if (r[m_owner]) begin
      g = m_owner;
    end else begin
      nxt = -1;
    end
    ok = (g >= 0) && (a[(g < 0) ? 0 : g] < int'(MS));

    check("gnt0", 64'(gnt0), 64'(g == 0));
    check("gnt1", 64'(gnt1), 64'(g == 1));
    check("excl", 64'(gnt0 & gnt1), 64'd0);
    check("ram_en", 64'(ram_en), 64'(ok));
    check("ram_we", 64'(ram_we), ok ? 64'(w[g]) : 64'd0);
    check("ram_addr", 64'(ram_addr), ok ? 64'(a[g]) : 64'd0);
    check("ram_di", 64'(ram_di), ok ? 64'(d[g]) : 64'd0);

    if (chk_wait) begin
      w0 = (r[0] && g != 0) ? w0 + 1 : 0;
      w1 = (r[1] && g != 1) ? w1 + 1 : 0;
      check("wait0", 64'(w0 <= 1), 64'd1);
      check("wait1", 64'(w1 <= 1), 64'd1);
    end

    m_rv0  = (g == 0) && ok && !w[0];
    m_rv1  = (g == 1) && ok && !w[1];
    m_err0 = (g == 0) && !ok;
    m_err1 = (g == 1) && !ok;
    if (ok) begin
      if (w[g]) m_mem[a[g]] = d[g];
      else      m_rdata = m_mem[a[g]];
    end
    if (g >= 0) begin
      m_prio = 1 - g;
      nxt    = l[g] ? g : -1;
    end
    m_owner = nxt;
    m_g     = g;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0; chk_wait = 0; w0 = 0; w1 = 0; m_g = -1;
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    req0 = 1; req1 = 1;
    #1;
    check("rst_gnt0", 64'(gnt0), 64'd0);
    check("rst_gnt1", 64'(gnt1), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_rvalid0", 64'(rvalid0), 64'd0);
    check("rst_err1", 64'(err1), 64'd0);
    idle_inputs();
    rst_n = 1;
    repeat (3) cycle();

    // Tie between two reads: alternating grants
    for (int i = 0; i < 4; i++) begin
      req0 = 1; we0 = 0; addr0 = AW'(3); req1 = 1; we1 = 0; addr1 = AW'(5);
      #1 check("tie_addr", 64'(ram_addr), (i % 2 == 0) ? 64'd3 : 64'd5);
      cycle();
    end
    idle_inputs();

    // Locked write burst from requester 0 while requester 1 waits
    req1 = 1; we1 = 0; addr1 = AW'(10);
    for (int i = 0; i < 4; i++) begin
      req0 = 1; we0 = 1; addr0 = AW'(i); wdata0 = MW'(32'hA0 + i); lock0 = (i < 3);
      #1 check("burst_gnt1", 64'(gnt1), 64'd0);
      cycle();
    end
    req0 = 0; we0 = 0; lock0 = 0;
    #1 check("burst_gnt1_after", 64'(gnt1), 64'd1);
    cycle();
    req1 = 0; req0 = 1; we0 = 0; addr0 = AW'(2);
    cycle();
    idle_inputs();
    #1 check("burst_readback", 64'(rdata), 64'hA2);
    cycle();

    // Owner drops its request: idle cycle, then the other side gets in
    req0 = 1; we0 = 0; addr0 = AW'(1); lock0 = 1;
    cycle();
    req0 = 0; lock0 = 0; req1 = 1; we1 = 0; addr1 = AW'(4);
    #1 check("drop_gnt1", 64'(gnt1), 64'd0);
    cycle();
    #1 check("drop_gnt1_next", 64'(gnt1), 64'd1);
    cycle();
    idle_inputs();

    // Out-of-range read is granted but rejected
    req1 = 1; we1 = 0; addr1 = AW'(24);
    #1 check("oor_gnt1", 64'(gnt1), 64'd1);
    check("oor_ram_en", 64'(ram_en), 64'd0);
    cycle();
    idle_inputs();
    #1 check("oor_err1", 64'(err1), 64'd1);
    check("oor_rvalid1", 64'(rvalid1), 64'd0);
    cycle();

    // Reset pulse between grant and read return
    req0 = 1; we0 = 0; addr0 = AW'(7);
    #1 check("mid_gnt0", 64'(gnt0), 64'd1);
    #1 rst_n = 0;
    #1;
    check("mid_rst_gnt0", 64'(gnt0), 64'd0);
    check("mid_rst_en", 64'(ram_en), 64'd0);
    check("mid_rst_we", 64'(ram_we), 64'd0);
    check("mid_rst_addr", 64'(ram_addr), 64'd0);
    check("mid_rst_di", 64'(ram_di), 64'd0);
    model_reset();
    @(posedge clk);
    #1 check("mid_rvalid0", 64'(rvalid0), 64'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    repeat (3) cycle();
    req0 = 1; we0 = 0; addr0 = AW'(2); req1 = 1; we1 = 0; addr1 = AW'(6);
    #1 check("post_rst_tie", 64'(gnt0), 64'd1);
    cycle();
    idle_inputs();
    cycle();

    // Randomised traffic: first half without locks (fairness checked), then with locks
    chk_wait = 1; w0 = 0; w1 = 0; p0 = 0; p1 = 0;
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) chk_wait = 0;
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1;
        we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, MS + 3));
        wdata0 = MW'($urandom);
        lock0 = chk_wait ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1;
        we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, MS + 3));
        wdata1 = MW'($urandom);
        lock1 = chk_wait ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      end
      req0 = p0;
      req1 = p1;
      cycle();
      if (m_g == 0) p0 = 0;
      if (m_g == 1) p1 = 0;
    end
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port BRAM (registered read, 1-cycle latency, write-first) between two datapath clients, e.g. the NTT core and the sampler/encoder. It grants at most one access per cycle with round-robin fairness and an optional lock for back-to-back bursts. It drives the RAM enable, write-enable, address and write-data, and routes the returned read data back to the requester that issued the read. Out-of-range addresses are rejected before reaching the RAM.

## Interface
- MEM_WIDTH, 32, data width in bits
- MEM_SIZE, 24, number of RAM words; ADDR_W = $clog2(MEM_SIZE)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request from requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  MEM_WIDTH  write data
- lock0 / lock1  in  1  keep ownership after this access
- gnt0 / gnt1  out  1  combinational; access accepted this cycle
- err0 / err1  out  1  registered; pulses 1 cycle after a rejected out-of-range request
- rvalid0 / rvalid1  out  1  registered; read data valid for that requester
- rdata  out  MEM_WIDTH  shared read data, equal to ram_dout
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_di  out  MEM_WIDTH  RAM write data
- ram_dout  in  MEM_WIDTH  RAM read data

## Operation
- State: owner ∈ {FREE, OWN0, OWN1}; rr_prio (1 bit, requester preferred on tie); rvalid0/1 and err0/1 registers.
- A request is valid when reqN=1 and addrN < MEM_SIZE. A request with reqN=1 and addrN ≥ MEM_SIZE is invalid: it is granted (gntN=1) so the requester advances, but it is never forwarded to the RAM, and errN=1 is set on the next cycle.
- FREE:
  - If only one requester has reqN=1, grant it.
  - If both have reqN=1, grant the requester named by rr_prio.
- OWNn: only requester n can be granted. The other requester's gnt stays 0 even if it requests.
- On every grant to n (valid or invalid): rr_prio ← the other requester.
- Ownership transitions:
  - Grant to n with lockn=1 → OWNn.
  - Grant to n with lockn=0 → FREE.
  - In OWNn with reqn=0 → FREE. No grant is issued that cycle, including to the other requester.
- RAM drive for a valid granted access by n: ram_en=1, ram_we=wen, ram_addr=addrn, ram_di=wdatan.
- RAM drive with no valid grant: ram_en=0, ram_we=0, ram_addr=0, ram_di=0.
- A valid granted read sets rvalidn=1 on the next cycle; rdata then carries RAM[addr].
- Writes never raise rvalid. The RAM's write-first dout is ignored.
- At most one of gnt0/gnt1, rvalid0/rvalid1 and err0/err1 is high in any cycle.

## Timing
- Reset (asserted asynchronously, released synchronously inside the design):
  - owner=FREE, rr_prio=0 (requester 0 wins the first tie).
  - rvalid0/1=0, err0/1=0.
  - While rst_n=0, gnt0/1=0 and all RAM outputs are 0 (forced combinationally).
- Grant-to-RAM latency: 0 cycles (combinational path from reqN to ram_en).
- Read latency: grant in cycle t → rvalidn=1 and data on rdata in cycle t+1.
- Throughput: one access per cycle. Back-to-back reads give continuous rvalid.
- A requester holds req/we/addr/wdata/lock stable until it sees gnt. Changes while gnt=0 are allowed and are re-evaluated each cycle.
- Reset mid-read (granted in t, rst_n low before t+1): rvalid is not asserted, the data is discarded, and the requester must reissue.
- Write then read of the same address in consecutive cycles returns the new data. Ordering follows the RAM port.

## Test plan
- After reset, req0=req1=1, both reads, addr0=3, addr1=5, held for 4 cycles → gnt sequence 0,1,0,1; ram_addr 3,5,3,5; rvalid0/rvalid1 alternate one cycle later; rdata matches preloaded RAM[3]/RAM[5].
- Requester 0: 4-word burst writing 0xA0..0xA3 to addr 0..3, lock0=1 on the first 3 and 0 on the last; req1 active throughout → gnt1=0 for 4 cycles, then gnt1=1 in cycle 5; a subsequent read of addr 2 returns 0xA2.
- In OWN0, req0 dropped while req1=1 → no grant that cycle; next cycle gnt1=1 and owner FREE.
- req1=1, addr1=24 (MEM_SIZE=24) → gnt1=1, ram_en=0, err1=1 one cycle later, rvalid1 stays 0.
- Requester 0 read of addr 7 granted, then rst_n pulsed low before the next edge → rvalid0 stays 0, all outputs 0 during reset, first tie after release goes to requester 0.
- Randomised 1000 cycles against a scoreboard model → no simultaneous grants, every valid read returns the last written value, no requester waits more than 1 cycle when neither side holds a lock.
